// File: rtl/uart_rx_pkg.sv
// ---------------------------------------------------------------------------
// uart_rx_pkg
// Shared definitions for the fabric-side UART receiver and its byte FIFO.
//
// Contents:
//   DATA_BITS             - payload bits per 8N1 frame
//   DEFAULT_CLKS_PER_BIT  - FAB_CLK cycles per bit (40 MHz / 115200 baud)
//   DEFAULT_FIFO_DEPTH    - receive FIFO entries (power of two)
//   DEFAULT_ADDR_W        - log2(DEFAULT_FIFO_DEPTH)
//   rx_state_e            - receiver FSM state encoding
// ---------------------------------------------------------------------------
package uart_rx_pkg;

  localparam int DATA_BITS            = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 347;
  localparam int DEFAULT_FIFO_DEPTH   = 16;
  localparam int DEFAULT_ADDR_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage : uart_rx_pkg

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO with occupancy count.
//
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-high reset; empties the FIFO
//   push       in   write push_data this cycle (ignored when full unless a
//                   pop happens in the same cycle)
//   push_data  in   WIDTH  data to write
//   pop        in   remove the head entry (ignored when empty)
//   head_data  out  WIDTH  head entry; reads 0 while empty
//   count      out  ADDR_W+1  entries held, 0..DEPTH
//   full       out  count == DEPTH
//   empty      out  count == 0
//
// A simultaneous push and pop on a full FIFO performs both, so the count
// stays at DEPTH. A pop on an empty FIFO is dropped even if a push arrives
// in the same cycle, because there is no head word to hand out yet.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  head_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;

  logic do_push;
  logic do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign count     = count_q;
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Qualify the requests: a pop needs data present, and a push into a full
  // FIFO is only accepted when a pop frees the head slot in the same cycle.
  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
  end

  // Next-state for storage, pointers and occupancy. Pointers are ADDR_W
  // bits wide, so incrementing past DEPTH-1 wraps naturally.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + ADDR_W'(1);
    end

    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
      2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule : sync_fifo

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receives 8N1 frames from the MSS UART_1 TXD line, buffers the bytes in a
// FWFT FIFO and presents them on a valid/ready stream to the LCD command
// logic. Reports framing errors and FIFO overflow.
//
// Ports:
//   FAB_CLK     in   fabric clock (only clock)
//   RESET       in   synchronous active-high reset
//   RXD         in   asynchronous serial input, idle high
//   RX_DATA     out  8  byte at the FIFO head; valid while RX_VALID=1
//   RX_VALID    out  FIFO not empty
//   RX_READY    in   consumer accepts head byte (pop on RX_VALID&&RX_READY)
//   FRAME_ERR   out  one-cycle pulse when a stop bit samples 0
//   OVERFLOW    out  sticky; a byte was dropped because the FIFO was full
//   OVF_CLR     in   clears OVERFLOW (a new overflow in the same cycle wins)
//   FIFO_COUNT  out  ADDR_W+1  bytes held, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_W       = DEFAULT_ADDR_W
) (
  input  logic                  FAB_CLK,
  input  logic                  RESET,
  input  logic                  RXD,
  output logic [DATA_BITS-1:0]  RX_DATA,
  output logic                  RX_VALID,
  input  logic                  RX_READY,
  output logic                  FRAME_ERR,
  output logic                  OVERFLOW,
  input  logic                  OVF_CLR,
  output logic [ADDR_W:0]       FIFO_COUNT
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS);

  // START waits half a bit so that every later sample lands mid-bit.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  rxd_s;

  rx_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overflow_q, overflow_d;

  logic                  push;
  logic                  pop;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Two-flop synchroniser; both stages reset to the idle-high line level
  // so a reset never fabricates a start bit.
  always_comb begin
    sync1_d = RXD;
    sync2_d = sync1_q;
  end

  assign rxd_s = sync2_q;

  // Receiver FSM. STOP returns to IDLE at mid stop bit, which leaves half a
  // bit of margin for a back-to-back start edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rxd_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line that is high again at mid start bit was only a glitch.
          state_d   = rxd_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxd_s, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (rxd_s) begin
            push = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign pop = RX_READY && !fifo_empty;

  // Sticky overflow. A push into a full FIFO only drops the byte when no
  // pop frees a slot in the same cycle; a fresh drop beats OVF_CLR.
  always_comb begin
    overflow_d = overflow_q;
    if (OVF_CLR) begin
      overflow_d = 1'b0;
    end
    if (push && fifo_full && !pop) begin
      overflow_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  // The byte being pushed is the shift register contents: the last data bit
  // was shifted in a full bit period before the stop-bit sample.
  sync_fifo #(
    .WIDTH  (DATA_BITS),
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk       (FAB_CLK),
    .reset     (RESET),
    .push      (push),
    .push_data (shift_q),
    .pop       (RX_READY),
    .head_data (RX_DATA),
    .count     (FIFO_COUNT),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign RX_VALID  = !fifo_empty;
  assign FRAME_ERR = frame_err_q;
  assign OVERFLOW  = overflow_q;

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Drives 8N1 frames into uart_rx_fifo and compares the byte stream, count,
// framing-error pulses and overflow flag against a queue-based model of the
// receiver's expected behaviour. A shorter bit period keeps the run short;
// the receiver's timing is relative to CLKS_PER_BIT throughout.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int CPB   = 101;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rxd;
  logic [7:0]    rxData;
  logic          rxValid;
  logic          rxReady;
  logic          frameErr;
  logic          overflow;
  logic          ovfClr;
  logic [AW:0]   fifoCount;

  int errorCount   = 0;
  int checkCount   = 0;
  int frameErrSeen = 0;
  int frameErrBase;
  int expectedErrs;

  logic [7:0] modelQ[$];
  logic       modelOverflow;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .ADDR_W       (AW)
  ) dut (
    .FAB_CLK    (clk),
    .RESET      (reset),
    .RXD        (rxd),
    .RX_DATA    (rxData),
    .RX_VALID   (rxValid),
    .RX_READY   (rxReady),
    .FRAME_ERR  (frameErr),
    .OVERFLOW   (overflow),
    .OVF_CLR    (ovfClr),
    .FIFO_COUNT (fifoCount)
  );

  // Count every cycle FRAME_ERR is seen high, so pulse width is visible.
  always @(negedge clk) begin
    if (frameErr) frameErrSeen++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Frame-level model: a good frame enqueues its byte unless the FIFO is
  // already full, in which case the byte is lost and overflow is flagged.
  task automatic modelFrame(input logic [7:0] data, input logic stopBit);
    if (stopBit) begin
      if (modelQ.size() < DEPTH) modelQ.push_back(data);
      else modelOverflow = 1'b1;
    end
  endtask

  task automatic driveBit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // mode 0: plain frame; mode 1: also check RX_VALID rise timing around
  // the stop-bit sample; mode 2: pulse RX_READY for the push cycle.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input int mode);
    int used;
    int waited;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
    if (!stopBit) begin
      rxd = 1'b0;
      repeat (CPB / 2 + 10) @(negedge clk);
      rxd = 1'b1;
      repeat (CPB - (CPB / 2 + 10)) @(negedge clk);
    end else if (mode == 1) begin
      rxd = 1'b1;
      repeat (CPB / 2 - 4) @(negedge clk);
      checkOutput("valid_before_stop_sample", rxValid, 1'b0);
      waited = 0;
      while (!rxValid && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      checkOutput("valid_rise_after_stop_sample", rxValid, 1'b1);
      used = CPB / 2 - 4 + waited;
      repeat (CPB - used) @(negedge clk);
    end else if (mode == 2) begin
      rxd = 1'b1;
      repeat (CPB / 2 + 2) @(negedge clk);
      checkOutput("head_before_simul_pop", rxData, modelQ[0]);
      rxReady = 1'b1;
      @(negedge clk);
      rxReady = 1'b0;
      void'(modelQ.pop_front());
      repeat (CPB - (CPB / 2 + 3)) @(negedge clk);
    end else begin
      driveBit(1'b1);
    end
    if (mode != 2) modelFrame(data, stopBit);
    else modelQ.push_back(data);
  endtask

  task automatic popCheck(input string tag);
    checkOutput({tag, "_valid"}, rxValid, 1'b1);
    checkOutput({tag, "_data"}, rxData, modelQ[0]);
    rxReady = 1'b1;
    @(negedge clk);
    rxReady = 1'b0;
    void'(modelQ.pop_front());
  endtask

  task automatic doReset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    modelQ.delete();
    modelOverflow = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       s;
    rxd = 1'b1;
    rxReady = 1'b0;
    ovfClr = 1'b0;
    reset = 1'b1;
    modelOverflow = 1'b0;
    @(negedge clk);
    doReset();

    checkOutput("reset_valid", rxValid, 1'b0);
    checkOutput("reset_data", rxData, 8'h00);
    checkOutput("reset_count", fifoCount, 0);
    checkOutput("reset_overflow", overflow, 1'b0);
    checkOutput("reset_frame_err", frameErr, 1'b0);

    // Single byte with latency check.
    idle(20);
    applyStimulus(8'hA5, 1'b1, 1);
    checkOutput("single_count", fifoCount, modelQ.size());
    popCheck("single_pop");
    @(negedge clk);
    checkOutput("single_empty", rxValid, 1'b0);

    // Glitch shorter than half a bit.
    frameErrBase = frameErrSeen;
    rxd = 1'b0;
    repeat (CPB / 2 - 15) @(negedge clk);
    idle(2 * CPB);
    checkOutput("glitch_valid", rxValid, 1'b0);
    checkOutput("glitch_frame_err", frameErrSeen - frameErrBase, 0);

    // Framing error.
    frameErrBase = frameErrSeen;
    applyStimulus(8'h3C, 1'b0, 0);
    idle(CPB);
    checkOutput("frame_err_pulse_cycles", frameErrSeen - frameErrBase, 1);
    checkOutput("frame_err_count", fifoCount, 0);

    // Random frames, some with bad stop bits, then drain in order.
    frameErrBase = frameErrSeen;
    expectedErrs = 0;
    for (int n = 0; n < 6; n++) begin
      b = 8'($urandom);
      s = ($urandom_range(0, 3) != 0);
      if (!s) expectedErrs++;
      applyStimulus(b, s, 0);
      idle($urandom_range(0, 20) + (s ? 0 : CPB));
    end
    checkOutput("rand_count", fifoCount, modelQ.size());
    checkOutput("rand_frame_errs", frameErrSeen - frameErrBase, expectedErrs);
    while (modelQ.size() > 0) begin
      popCheck("rand_pop");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    checkOutput("rand_drained", fifoCount, 0);

    // Overflow: 17 back-to-back bytes with no consumer.
    for (int n = 0; n <= 16; n++) applyStimulus(8'(n), 1'b1, 0);
    idle(5);
    checkOutput("ovf_count", fifoCount, modelQ.size());
    checkOutput("ovf_flag", overflow, modelOverflow);
    ovfClr = 1'b1;
    @(negedge clk);
    ovfClr = 1'b0;
    checkOutput("ovf_cleared", overflow, 1'b0);

    // Full FIFO with a pop in the push cycle: both happen, no overflow.
    b = 8'($urandom);
    applyStimulus(b, 1'b1, 2);
    checkOutput("simul_count", fifoCount, DEPTH);
    checkOutput("simul_no_ovf", overflow, 1'b0);
    while (modelQ.size() > 0) popCheck("ovf_pop");
    @(negedge clk);
    checkOutput("ovf_drained", fifoCount, 0);

    // Pop on empty is ignored.
    rxReady = 1'b1;
    repeat (3) @(negedge clk);
    rxReady = 1'b0;
    checkOutput("empty_pop_count", fifoCount, 0);

    // Reset in the middle of data bit 4 of 0xFF, with a byte buffered.
    applyStimulus(8'h12, 1'b1, 0);
    checkOutput("pre_reset_count", fifoCount, 1);
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b1);
    rxd = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    modelQ.delete();
    checkOutput("midreset_valid", rxValid, 1'b0);
    checkOutput("midreset_count", fifoCount, 0);
    checkOutput("midreset_data", rxData, 8'h00);
    checkOutput("midreset_overflow", overflow, 1'b0);
    idle(6 * CPB);
    checkOutput("midreset_no_stale_byte", fifoCount, 0);
    applyStimulus(8'h55, 1'b1, 0);
    checkOutput("post_reset_count", fifoCount, 1);
    popCheck("post_reset_pop");

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule : tb_uart_rx_fifo
